// File: rtl/crc_check.sv
// Receive-side TLP link check: serial CRC-16 recompute over {seq, payload},
// in-order sequence check, and one ACK/NAK request per accepted frame.
module crc_check #(
    parameter int NBITS = 16,
    parameter int SEQW  = 12,
    parameter int PLW   = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [127:0]     dataIn,
    output logic             busy,
    output logic             vld,
    output logic [PLW-1:0]   dataOut,
    output logic [SEQW-1:0]  seqOut,
    output logic             ack,
    output logic             nak,
    output logic [SEQW-1:0]  ackSeq,
    output logic             crcErr
);

    localparam int FRW     = 128;
    localparam int MSGW    = SEQW + PLW;
    localparam int SEQ_LSB = PLW + NBITS;
    localparam int TOP_LSB = SEQ_LSB + SEQW;
    localparam int CW      = $clog2(FRW);

    localparam logic [NBITS-1:0] POLY = 'h1021;
    localparam logic [NBITS-1:0] INIT = '1;
    localparam logic [SEQW-1:0]  HALF = {1'b1, {(SEQW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [FRW-1:0]   frame;
    logic [NBITS-1:0] lfsr, lfsr_step;
    logic [CW-1:0]    cnt, bit_idx;
    logic             fb;
    logic [SEQW-1:0]  next_seq, next_seq_nx;
    logic             nak_sched, nak_sched_nx;

    logic [SEQW-1:0]  seq, seq_diff, last_seq;
    logic             crc_ok, in_order, dup;
    logic             dec_vld, dec_ack, dec_nak, dec_err;
    logic [SEQW-1:0]  dec_ackseq;

    assign busy = (state != IDLE);

    // Message bits leave MSB first, from the top of seq down to payload bit 0.
    assign bit_idx   = CW'(MSGW + NBITS - 1) - cnt;
    assign fb        = lfsr[NBITS-1] ^ frame[bit_idx];
    assign lfsr_step = {lfsr[NBITS-2:0], 1'b0} ^ (fb ? POLY : '0);

    assign seq      = frame[SEQ_LSB +: SEQW];
    assign seq_diff = next_seq - seq;
    assign last_seq = next_seq - SEQW'(1);
    assign crc_ok   = (lfsr == frame[NBITS-1:0]) && (frame[FRW-1:TOP_LSB] == '0);
    assign in_order = (seq_diff == '0);
    assign dup      = !in_order && (seq_diff <= HALF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value held and infer a latch.
        state_nx     = state;
        next_seq_nx  = next_seq;
        nak_sched_nx = nak_sched;
        dec_vld      = 1'b0;
        dec_ack      = 1'b0;
        dec_nak      = 1'b0;
        dec_err      = 1'b0;
        dec_ackseq   = last_seq;
        case (state)
            IDLE:   if (we) state_nx = CHECK;
            CHECK:  if (cnt == CW'(MSGW - 1)) state_nx = REPORT;
            REPORT: begin
                state_nx = IDLE;
                if (!crc_ok) begin
                    dec_err = 1'b1;
                    if (!nak_sched) begin
                        dec_nak      = 1'b1;
                        nak_sched_nx = 1'b1;
                    end
                end else if (in_order) begin
                    dec_vld      = 1'b1;
                    dec_ack      = 1'b1;
                    dec_ackseq   = seq;
                    next_seq_nx  = next_seq + SEQW'(1);
                    nak_sched_nx = 1'b0;
                end else if (dup) begin
                    dec_ack = 1'b1;
                end else if (!nak_sched) begin
                    dec_nak      = 1'b1;
                    nak_sched_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame     <= '0;
            lfsr      <= INIT;
            cnt       <= '0;
            next_seq  <= '0;
            nak_sched <= 1'b0;
            vld       <= 1'b0;
            ack       <= 1'b0;
            nak       <= 1'b0;
            crcErr    <= 1'b0;
            dataOut   <= '0;
            seqOut    <= '0;
            ackSeq    <= '0;
        end else begin
            next_seq  <= next_seq_nx;
            nak_sched <= nak_sched_nx;
            vld       <= dec_vld;
            ack       <= dec_ack;
            nak       <= dec_nak;
            crcErr    <= dec_err;
            if (dec_vld) begin
                dataOut <= frame[NBITS +: PLW];
                seqOut  <= seq;
            end
            if (dec_ack || dec_nak) ackSeq <= dec_ackseq;

            if (state == IDLE && we) begin
                frame <= dataIn;
                lfsr  <= INIT;
                cnt   <= '0;
            end else if (state == CHECK) begin
                lfsr <= lfsr_step;
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: delivery, CRC errors, NAK suppression,
// duplicates, out-of-order frames, sequence wrap, busy and mid-frame reset.
module tb_crc_check;

    localparam logic [79:0] PL0 = 80'h0123_4567_89AB_CDEF_0011;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         we  = 1'b0;
    logic [127:0] dataIn = '0;
    logic         busy, vld, ack, nak, crcErr;
    logic [79:0]  dataOut;
    logic [11:0]  seqOut, ackSeq;

    int n_tests = 0;
    int n_fail  = 0;

    crc_check dut (
        .clk(clk), .rst(rst), .we(we), .dataIn(dataIn),
        .busy(busy), .vld(vld), .dataOut(dataOut), .seqOut(seqOut),
        .ack(ack), .nak(nak), .ackSeq(ackSeq), .crcErr(crcErr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc16(input logic [91:0] m);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 91; i >= 0; i--) begin
            if (c[15] ^ m[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [79:0] pl_of(input logic [11:0] s);
        return PL0 ^ {68'h0, s};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pulse vector order: {vld, ack, nak, crcErr}
    task automatic check_pulses(input string tag, input logic [3:0] exp);
        check(tag, 128'({vld, ack, nak, crcErr}), 128'(exp));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pulses"}, 128'({busy, vld, ack, nak, crcErr}), 128'(0));
        check({tag, "_dataOut"}, 128'(dataOut), 128'(0));
        check({tag, "_seqOut"}, 128'(seqOut), 128'(0));
        check({tag, "_ackSeq"}, 128'(ackSeq), 128'(0));
    endtask

    // Sends one frame and returns one step after edge E+93 (the pulse cycle).
    task automatic send(input logic [11:0] s, input logic [79:0] pl,
                        input logic [15:0] crc_xor, input logic [19:0] top);
        @(negedge clk);
        dataIn = {top, s, pl, crc16({s, pl}) ^ crc_xor};
        we     = 1'b1;
        @(posedge clk);
        #1;
        we     = 1'b0;
        dataIn = '1;
        check("busy_set", 128'(busy), 128'(1));
        check_pulses("quiet_e1", 4'b0000);
        repeat (92) @(posedge clk);
        #1;
        check_pulses("quiet_e92", 4'b0000);
        check("busy_e92", 128'(busy), 128'(1));
        @(posedge clk);
        #1;
        check("busy_clr", 128'(busy), 128'(0));
    endtask

    task automatic deliver(input string tag, input logic [11:0] s);
        send(s, pl_of(s), 16'h0, 20'h0);
        check_pulses({tag, "_pulses"}, 4'b1100);
        check({tag, "_ackSeq"}, 128'(ackSeq), 128'(s));
        check({tag, "_dataOut"}, 128'(dataOut), 128'(pl_of(s)));
        check({tag, "_seqOut"}, 128'(seqOut), 128'(s));
    endtask

    initial begin
        logic seen;

        // T1: reset state, then first in-order frame
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        deliver("t1_seq0", 12'h000);

        // T2: CRC errors, NAK suppression, recovery
        send(12'h001, pl_of(12'h001), 16'h0001, 20'h0);
        check_pulses("t2_bad1_pulses", 4'b0011);
        check("t2_bad1_ackSeq", 128'(ackSeq), 128'(0));
        check("t2_bad1_dataOut", 128'(dataOut), 128'(PL0));
        send(12'h001, pl_of(12'h001), 16'h0001, 20'h0);
        check_pulses("t2_bad2_pulses", 4'b0001);
        deliver("t2_seq1", 12'h001);

        // T3: duplicate resend
        deliver("t3_seq2", 12'h002);
        deliver("t3_seq3", 12'h003);
        deliver("t3_seq4", 12'h004);
        send(12'h002, pl_of(12'h002), 16'h0, 20'h0);
        check_pulses("t3_dup_pulses", 4'b0100);
        check("t3_dup_ackSeq", 128'(ackSeq), 128'(4));
        check("t3_dup_dataOut", 128'(dataOut), 128'(pl_of(12'h004)));

        // T4: frame ahead of expected sequence
        send(12'h007, pl_of(12'h007), 16'h0, 20'h0);
        check_pulses("t4_ahead_pulses", 4'b0010);
        check("t4_ahead_ackSeq", 128'(ackSeq), 128'(4));
        deliver("t4_seq5", 12'h005);

        // T5: preload the sequence counter near the wrap point
        @(negedge clk);
        force dut.next_seq = 12'hFFE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        release dut.next_seq;
        deliver("t5_seqFFE", 12'hFFE);
        deliver("t5_seqFFF", 12'hFFF);
        deliver("t5_wrap0", 12'h000);
        send(12'h801, pl_of(12'h801), 16'h0, 20'h0);
        check_pulses("t5_dup2048_pulses", 4'b0100);
        check("t5_dup2048_ackSeq", 128'(ackSeq), 128'(0));
        send(12'h800, pl_of(12'h800), 16'h0, 20'h0);
        check_pulses("t5_ahead2049_pulses", 4'b0010);
        check("t5_ahead2049_ackSeq", 128'(ackSeq), 128'(0));
        send(12'h001, pl_of(12'h001), 16'h0, 20'h00001);
        check_pulses("t5_topbits_pulses", 4'b0001);
        deliver("t5_seq1", 12'h001);

        // T6: we ignored while busy, then reset mid-frame
        @(negedge clk);
        dataIn = {20'h0, 12'h002, pl_of(12'h002), crc16({12'h002, pl_of(12'h002)})};
        we     = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 39; k++) begin
            @(negedge clk);
            dataIn = {$urandom(), $urandom(), $urandom(), $urandom()};
            we     = 1'b1;
            @(posedge clk);
            #1;
            check("t6_busy", 128'(busy), 128'(1));
        end
        @(posedge clk);
        #2;
        we  = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("t6_rst");
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            seen = seen | vld | ack | nak | crcErr | busy;
        end
        check("t6_no_pulse", 128'(seen), 128'(0));
        send(12'h000, pl_of(12'h000), 16'h8000, 20'h0);
        check_pulses("t6_bad_pulses", 4'b0011);
        check("t6_bad_ackSeq", 128'(ackSeq), 128'(12'hFFF));
        deliver("t6_seq0", 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
